// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding and
// the reverse double-dabble digit-adjust constants.
package bcd_to_binary_converter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESH    = 4'd8;
    localparam logic [3:0] ADJ_SUB       = 4'd3;

    function automatic logic digit_is_bcd(input logic [3:0] d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_to_binary_converter_if.sv
// Start/done handshake and result bundle between digit entry and the converter.
interface bcd_to_binary_converter_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BIN_W-1:0]      bin_out;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  error;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, overflow, error
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, overflow, error
    );
endinterface

// File: rtl/bcd_to_binary_converter_digit_adjust.sv
// One BCD digit correction step of reverse double-dabble: digits >= 8 lose 3.
module bcd_to_binary_converter_digit_adjust
    import bcd_to_binary_converter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;
endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential reverse double-dabble BCD-to-binary converter, one shift per clock.
// Optional BCD_DIGIT_CHECK_EN rejects non-BCD digits with an error flag.
module bcd_to_binary_converter
    import bcd_to_binary_converter_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    bcd_to_binary_converter_if.slave   bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;

    logic [2*ACC_W-1:0] shifted;
    logic [ACC_W-1:0]   bcd_adj;

    assign shifted = {bcd_q, acc_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_to_binary_converter_digit_adjust u_adj (
            .digit_i (shifted[ACC_W + 4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_is_bcd(bus.bcd_in[4*i +: 4])) bad_digit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bcd_d   = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d   = 1'b0;
                    if (bad_digit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                        ovf_d   = 1'b0;
                    end
`endif
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_adj;
                acc_d = shifted[ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    // Overflow judged on the full accumulator, not the truncated result.
                    if ((acc_d >> BIN_W) != '0) begin
                        bin_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = acc_d[BIN_W-1:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign bus.error = err_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.bin_out  = bin_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);

endmodule
